// File: rtl/anticoinc_gate_core.sv
// -----------------------------------------------------------------------------
// anticoinc_gate_core
//   Anti-coincidence trigger gate. A rising edge on trig_in opens a look-ahead
//   window of delay_cycles cycles. The trigger is passed as a trig_out pulse
//   only if no veto was active anywhere in that window. Accepted, vetoed and
//   busy-dropped triggers are counted in saturating counters.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-high reset
//   enable        0 forces the gate idle and ignores trigger edges
//   cnt_clear     single-cycle pulse, zeroes all counters (wins over increments)
//   delay_cycles  look-ahead window length, captured when a window opens
//   veto_len      cycles a veto is held after veto_in falls
//   pulse_len     trig_out width in cycles (0 behaves as 1), captured at pulse start
//   trig_in       primary trigger (synchronous)
//   veto_in       veto input (synchronous)
//   trig_out      registered accepted-trigger pulse
//   busy          high while a window is open or a pulse is being emitted
//   accept_count  triggers passed
//   veto_count    triggers suppressed by a veto
//   drop_count    trigger edges ignored while busy
// -----------------------------------------------------------------------------
module anticoinc_gate_core #(
  parameter int DLY_W  = 8,
  parameter int VETO_W = 8,
  parameter int PW_W   = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cnt_clear,
  input  logic [DLY_W-1:0]  delay_cycles,
  input  logic [VETO_W-1:0] veto_len,
  input  logic [PW_W-1:0]   pulse_len,
  input  logic              trig_in,
  input  logic              veto_in,
  output logic              trig_out,
  output logic              busy,
  output logic [CNT_W-1:0]  accept_count,
  output logic [CNT_W-1:0]  veto_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, ARMED, PULSE} state_t;

  state_t            state;
  logic              trig_prev;
  logic [VETO_W-1:0] hold_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic              vflag;
  logic [PW_W-1:0]   pulse_cnt;

  logic              trig_edge;
  logic              veto_act;
  logic [PW_W-1:0]   pulse_load;
  logic              arm_ev;
  logic              accept_ev;
  logic              veto_ev;
  logic              drop_ev;

  assign trig_edge  = trig_in & ~trig_prev;
  assign veto_act   = veto_in | (hold_cnt != '0);
  assign pulse_load = (pulse_len == '0) ? PW_W'(1) : pulse_len;

  // Decision strobes for the current cycle; shared by the FSM and the counters
  // so both see exactly the same event.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    arm_ev    = 1'b0;
    accept_ev = 1'b0;
    veto_ev   = 1'b0;
    drop_ev   = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (trig_edge) begin
            if (delay_cycles != '0) arm_ev    = 1'b1;
            else if (veto_act)      veto_ev   = 1'b1;
            else                    accept_ev = 1'b1;
          end
        end
        ARMED: begin
          drop_ev = trig_edge;
          // Last window cycle: this cycle's veto is part of the decision.
          if (dly_cnt == DLY_W'(1)) begin
            if (vflag | veto_act) veto_ev   = 1'b1;
            else                  accept_ev = 1'b1;
          end
        end
        PULSE:   drop_ev = trig_edge;
        default: ;
      endcase
    end
  end

  // Edge and veto-hold tracking run regardless of enable.
  // trig_prev resets high so a level already high at reset release is no edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_prev <= 1'b1;
      hold_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      trig_prev <= trig_in;
      if (veto_in)              hold_cnt <= veto_len;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - VETO_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      trig_out  <= 1'b0;
      busy      <= 1'b0;
      dly_cnt   <= '0;
      vflag     <= 1'b0;
      pulse_cnt <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm_ev) begin
            dly_cnt <= delay_cycles;
            vflag   <= veto_act;
            state   <= ARMED;
            busy    <= 1'b1;
          end else if (accept_ev) begin
            pulse_cnt <= pulse_load;
            trig_out  <= 1'b1;
            state     <= PULSE;
            busy      <= 1'b1;
          end
        end
        ARMED: begin
          dly_cnt <= dly_cnt - DLY_W'(1);
          vflag   <= vflag | veto_act;
          if (accept_ev) begin
            pulse_cnt <= pulse_load;
            trig_out  <= 1'b1;
            state     <= PULSE;
          end else if (veto_ev) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PULSE: begin
          if (pulse_cnt <= PW_W'(1)) begin
            trig_out <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - PW_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic ev);
    return (ev && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Clear takes priority: an event coinciding with cnt_clear is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accept_count <= '0;
      veto_count   <= '0;
      drop_count   <= '0;
    end else if (cnt_clear) begin
      accept_count <= '0;
      veto_count   <= '0;
      drop_count   <= '0;
    end else begin
      accept_count <= sat_inc(accept_count, accept_ev);
      veto_count   <= sat_inc(veto_count,   veto_ev);
      drop_count   <= sat_inc(drop_count,   drop_ev);
    end
  end

endmodule

// File: tb/tb_anticoinc_gate_core.sv
// -----------------------------------------------------------------------------
// tb_anticoinc_gate_core
//   Directed test of anticoinc_gate_core built with 4-bit counters so that
//   saturation is reachable. Inputs change 1 ns after a rising edge; outputs
//   are observed at that same point, i.e. they show the registered result of
//   the edge just taken.
// -----------------------------------------------------------------------------
module tb_anticoinc_gate_core;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             cnt_clear;
  logic [7:0]       delay_cycles;
  logic [7:0]       veto_len;
  logic [7:0]       pulse_len;
  logic             trig_in;
  logic             veto_in;
  logic             trig_out;
  logic             busy;
  logic [CNT_W-1:0] accept_count;
  logic [CNT_W-1:0] veto_count;
  logic [CNT_W-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  anticoinc_gate_core #(
    .DLY_W (8),
    .VETO_W(8),
    .PW_W  (8),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cnt_clear   (cnt_clear),
    .delay_cycles(delay_cycles),
    .veto_len    (veto_len),
    .pulse_len   (pulse_len),
    .trig_in     (trig_in),
    .veto_in     (veto_in),
    .trig_out    (trig_out),
    .busy        (busy),
    .accept_count(accept_count),
    .veto_count  (veto_count),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_clear = 1'b1;
    tick(1);
    cnt_clear = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    cnt_clear    = 1'b0;
    delay_cycles = 8'd0;
    veto_len     = 8'd0;
    pulse_len    = 8'd1;
    trig_in      = 1'b0;
    veto_in      = 1'b0;

    // Reset state
    tick(2);
    check("rst_trig_out", 32'(trig_out), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_accept",   32'(accept_count), 32'd0);
    check("rst_veto",     32'(veto_count),   32'd0);
    check("rst_drop",     32'(drop_count),   32'd0);
    reset = 1'b0;
    tick(2);

    // T1: delay 3, pulse 2, no veto; pulse at N+4, N+5; pulse_len change mid-pulse ignored
    delay_cycles = 8'd3;
    pulse_len    = 8'd2;
    trig_in = 1'b1; tick(1);               // edge at N
    check("t1_busy_armed", 32'(busy), 32'd1);
    check("t1_n1_low",     32'(trig_out), 32'd0);
    trig_in = 1'b0; tick(2);
    check("t1_n3_low",     32'(trig_out), 32'd0);
    tick(1);
    check("t1_n4_high",    32'(trig_out), 32'd1);
    pulse_len = 8'd7;
    tick(1);
    check("t1_n5_high",    32'(trig_out), 32'd1);
    tick(1);
    check("t1_n6_low",     32'(trig_out), 32'd0);
    check("t1_n6_idle",    32'(busy), 32'd0);
    check("t1_accept",     32'(accept_count), 32'd1);
    pulse_len = 8'd2;
    clear_counts();
    check("clr_accept",    32'(accept_count), 32'd0);

    // T2a: veto exactly on the last window cycle N+3 -> vetoed
    trig_in = 1'b1; tick(1);               // N
    trig_in = 1'b0; tick(2);               // N+1, N+2
    veto_in = 1'b1; tick(1);               // N+3
    veto_in = 1'b0;
    check("t2a_veto_cnt",  32'(veto_count), 32'd1);
    check("t2a_not_busy",  32'(busy), 32'd0);
    check("t2a_no_pulse",  32'(trig_out), 32'd0);
    tick(3);
    check("t2a_no_pulse2", 32'(trig_out), 32'd0);
    check("t2a_accept0",   32'(accept_count), 32'd0);

    // T2b: veto at N+4 is outside the window -> accepted
    trig_in = 1'b1; tick(1);               // N
    trig_in = 1'b0; tick(3);               // N+1..N+3
    check("t2b_n4_high",   32'(trig_out), 32'd1);
    veto_in = 1'b1; tick(1);               // N+4
    veto_in = 1'b0;
    check("t2b_n5_high",   32'(trig_out), 32'd1);
    tick(2);
    check("t2b_accept",    32'(accept_count), 32'd1);
    check("t2b_veto_cnt",  32'(veto_count), 32'd1);

    // T3: delay 0, veto_len 5: veto at M covers M..M+5
    clear_counts();
    delay_cycles = 8'd0;
    veto_len     = 8'd5;
    veto_in = 1'b1; tick(1);               // M
    veto_in = 1'b0; tick(4);               // M+1..M+4
    trig_in = 1'b1; tick(1);               // edge at M+5
    trig_in = 1'b0;
    check("t3a_veto_cnt",  32'(veto_count), 32'd1);
    check("t3a_no_pulse",  32'(trig_out), 32'd0);
    check("t3a_idle",      32'(busy), 32'd0);
    tick(3);
    veto_in = 1'b1; tick(1);               // M
    veto_in = 1'b0; tick(5);               // M+1..M+5
    trig_in = 1'b1; tick(1);               // edge at M+6
    trig_in = 1'b0;
    check("t3b_m7_high",   32'(trig_out), 32'd1);
    check("t3b_accept",    32'(accept_count), 32'd1);
    tick(3);
    check("t3b_veto_cnt",  32'(veto_count), 32'd1);

    // T4: delay 4, pulse 3; edges at N, N+2 (armed), N+6 (pulse)
    clear_counts();
    veto_len     = 8'd0;
    delay_cycles = 8'd4;
    pulse_len    = 8'd3;
    trig_in = 1'b1; tick(1);               // N
    trig_in = 1'b0; tick(1);               // N+1
    trig_in = 1'b1; tick(1);               // N+2, dropped
    trig_in = 1'b0; tick(1);               // N+3
    check("t4_n4_low",     32'(trig_out), 32'd0);
    tick(1);                               // N+4
    check("t4_n5_high",    32'(trig_out), 32'd1);
    tick(1);                               // N+5
    check("t4_n6_high",    32'(trig_out), 32'd1);
    trig_in = 1'b1; tick(1);               // N+6, dropped
    check("t4_n7_high",    32'(trig_out), 32'd1);
    trig_in = 1'b0; tick(1);               // N+7
    check("t4_n8_low",     32'(trig_out), 32'd0);
    check("t4_n8_idle",    32'(busy), 32'd0);
    check("t4_drop",       32'(drop_count), 32'd2);
    check("t4_accept",     32'(accept_count), 32'd1);

    // T5: trig_in held high through reset release -> no edge
    trig_in = 1'b1;
    reset   = 1'b1; tick(2);
    reset   = 1'b0; tick(4);
    check("t5_rel_no_pulse", 32'(trig_out), 32'd0);
    check("t5_rel_busy",     32'(busy), 32'd0);
    check("t5_rel_accept",   32'(accept_count), 32'd0);
    check("t5_rel_veto",     32'(veto_count), 32'd0);
    check("t5_rel_drop",     32'(drop_count), 32'd0);
    trig_in = 1'b0; tick(1);

    // T5: enable dropped mid-window, edges ignored while disabled
    delay_cycles = 8'd5;
    pulse_len    = 8'd2;
    trig_in = 1'b1; tick(1);
    trig_in = 1'b0; tick(1);
    check("t5_armed_busy",   32'(busy), 32'd1);
    enable = 1'b0; tick(1);
    check("t5_dis_busy",     32'(busy), 32'd0);
    check("t5_dis_trig",     32'(trig_out), 32'd0);
    trig_in = 1'b1; tick(1);
    trig_in = 1'b0; tick(8);
    check("t5_dis_no_pulse", 32'(trig_out), 32'd0);
    check("t5_dis_drop",     32'(drop_count), 32'd0);
    check("t5_dis_accept",   32'(accept_count), 32'd0);
    check("t5_dis_veto",     32'(veto_count), 32'd0);
    enable = 1'b1; tick(2);

    // Async reset mid-pulse drops trig_out without a clock edge
    delay_cycles = 8'd0;
    pulse_len    = 8'd5;
    trig_in = 1'b1; tick(1);
    trig_in = 1'b0;
    check("ar_pulse_high",   32'(trig_out), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("ar_async_low",    32'(trig_out), 32'd0);
    check("ar_async_busy",   32'(busy), 32'd0);
    tick(1);
    reset = 1'b0; tick(3);
    check("ar_no_resume",    32'(trig_out), 32'd0);

    // T6: pulse_len 0 acts as 1; accept_count saturates at 15
    pulse_len = 8'd0;
    trig_in = 1'b1; tick(1);
    check("t6_pw0_high",     32'(trig_out), 32'd1);
    trig_in = 1'b0; tick(1);
    check("t6_pw0_low",      32'(trig_out), 32'd0);
    for (int i = 0; i < 14; i++) begin
      trig_in = 1'b1; tick(1);
      trig_in = 1'b0; tick(1);
    end
    check("t6_count_15",     32'(accept_count), 32'd15);
    trig_in = 1'b1; tick(1);
    check("t6_16th_pulse",   32'(trig_out), 32'd1);
    trig_in = 1'b0; tick(1);
    check("t6_saturated",    32'(accept_count), 32'd15);

    // Clear coinciding with an accept: clear wins
    trig_in   = 1'b1;
    cnt_clear = 1'b1; tick(1);
    cnt_clear = 1'b0;
    trig_in   = 1'b0;
    check("t6_clr_pulse",    32'(trig_out), 32'd1);
    check("t6_clr_wins",     32'(accept_count), 32'd0);
    tick(2);
    check("t6_clr_stays",    32'(accept_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
